pcm2pwm_scheduler: RTL

Sequencing controller for the 8-bit PCM-to-PWM output stage. It buffers signed PCM samples from an upstream producer in a small FIFO and converts each one to an 8-bit offset-binary duty value. It drives the PWM stage's enable and duty inputs so that duty changes only on PWM period boundaries, and holds each sample for a fixed number of PWM periods. It also handles start/stop, priming, draining and underflow.

---
 rtl/pcm2pwm_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pcm2pwm_scheduler.sv
// PCM-to-PWM scheduler: buffers signed PCM samples, converts them to
// offset-binary duty, and updates duty only on PWM period boundaries.
// Ports: clk_i/rst_i (sync, active-high), start_i/stop_i control pulses,
// sample_i/sample_valid_i/sample_ready_o producer side, duty_o and
// pwm_enable_o to the PWM stage, fifo_level_o, underflow_o, busy_o status.
module pcm2pwm_scheduler #(
  parameter int FIFO_DEPTH         = 16,
  parameter int PRIME_LEVEL        = 8,
  parameter int PERIODS_PER_SAMPLE = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic [15:0]                   sample_i,
  input  logic                          sample_valid_i,
  output logic                          sample_ready_o,
  output logic [7:0]                    duty_o,
  output logic                          pwm_enable_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          underflow_o,
  output logic                          busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = (PERIODS_PER_SAMPLE > 1) ?
                      $clog2(PERIODS_PER_SAMPLE) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(PERIODS_PER_SAMPLE - 1);
  localparam logic [7:0]    MID     = 8'h80;

  typedef enum logic [1:0] {IDLE, PRIME, PLAY, DRAIN} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [7:0]    phase;
  logic [RW-1:0] rep;
  logic          push;
  logic          pop;
  logic          flush;
  logic          boundary;
  logic          prime_go;
  logic          has_data;
  logic          unused_lsb;

  // Only the top byte matters after conversion.
  assign unused_lsb = ^sample_i[7:0];

  assign sample_ready_o = (level != LW'(FIFO_DEPTH));
  assign fifo_level_o   = level;
  assign has_data       = (level != '0);
  assign push           = sample_valid_i && sample_ready_o;
  assign boundary       = pwm_enable_o && (phase == 8'hFF) &&
                          (rep == REP_MAX);
  assign flush          = (state == PRIME) && stop_i;
  assign prime_go       = (state == PRIME) && !stop_i &&
                          (level >= LW'(PRIME_LEVEL));
  assign pop            = prime_go || (boundary && has_data);

  // Samples are stored already converted to offset-binary duty.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {~sample_i[15], sample_i[14:8]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      duty_o       <= MID;
      pwm_enable_o <= 1'b0;
      underflow_o  <= 1'b0;
      busy_o       <= 1'b0;
      phase        <= '0;
      rep          <= '0;
    end else begin
      // phase/rep mirror the PWM stage counter while enabled.
      if (pwm_enable_o) phase <= phase + 1'b1;
      if (pwm_enable_o && phase == 8'hFF)
        rep <= (rep == REP_MAX) ? '0 : rep + 1'b1;
      unique case (state)
        IDLE: begin
          if (start_i && !stop_i) begin
            state       <= PRIME;
            busy_o      <= 1'b1;
            underflow_o <= 1'b0;
          end
        end
        PRIME: begin
          if (stop_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (prime_go) begin
            state        <= PLAY;
            duty_o       <= mem[rd_ptr];
            pwm_enable_o <= 1'b1;
            phase        <= '0;
            rep          <= '0;
          end
        end
        PLAY: begin
          if (boundary) begin
            if (has_data) begin
              duty_o <= mem[rd_ptr];
            end else begin
              duty_o      <= MID;
              underflow_o <= 1'b1;
            end
          end
          if (stop_i) state <= DRAIN;
        end
        DRAIN: begin
          if (boundary) begin
            if (has_data) begin
              duty_o <= mem[rd_ptr];
            end else begin
              state        <= IDLE;
              duty_o       <= MID;
              pwm_enable_o <= 1'b0;
              busy_o       <= 1'b0;
              phase        <= '0;
              rep          <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule
